flash_thermo_encoder: RTL and testbench
=======================================

# flash_thermo_encoder

Downstream conversion stage of the flash ADC. Consumes the 31-bit comparator thermometer word that the calibrated comparator bank produces and the ADC controller steers, and removes single-bit bubble errors. Converts the corrected word to a 5-bit binary code, optionally averages 2^AVG_LOG2 consecutive samples, and delivers results over a valid/ready handshake with overflow reporting.

## Interface
- N_CMP, 31, number of comparators / thermometer width (fixed at 31 for this ADC).
- CODE_BITS, 5, output code width; ceil(log2(N_CMP+1)).
- AVG_LOG2, 0, log2 of the averaging length; 0 = pass-through, legal range 0..4.

Ports:
- clk  in  1  conversion clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- en  in  1  conversion enable; driven high by system once comparator calibration is done.
- Q  in  31  comparator thermometer word; Q[0] is the lowest threshold.
- code  out  CODE_BITS  averaged binary code.
- code_valid  out  1  code holds an unconsumed result.
- code_ready  in  1  consumer accepts code.
- ovf  out  1  one-cycle pulse, result dropped because the output slot was full.
- bubble_cnt  out  8  saturating count of samples that needed bubble correction.

## Operation
- Stage S0: at each edge with en=1, Q is captured into q_r and v0 is set. With en=0, v0 is cleared.
- Stage S1: the corrected word t_c[i] is majority(q_r[i-1], q_r[i], q_r[i+1]), with q_r[-1]=1 and q_r[31]=0 at the boundaries.
  - bub = (t_c != q_r).
  - c_r = popcount(t_c), range 0..31, registered with v1 = v0.
  - When v1 and bub are both set, bubble_cnt increments, saturating at 255.
- Stage S2, accumulator:
  - sum is CODE_BITS+AVG_LOG2 bits wide. cnt is AVG_LOG2 bits wide.
  - On v1, sum += c_r and cnt += 1.
  - When cnt wraps, i.e. the 2^AVG_LOG2-th sample arrives, the result is (sum + c_r) >> AVG_LOG2 with truncation and no rounding. The result goes to the output slot, then sum and cnt are cleared.
  - With AVG_LOG2=0, every v1 sample is a result.
- Output slot: a single register holding code and code_valid.
  - A transfer completes at an edge where code_valid and code_ready are both 1.
  - The slot is free if code_valid=0, or if a transfer completes on the same edge. In that case a new result is loaded and code_valid=1.
  - If a result completes while the slot is not free, the result is dropped, ovf=1 for one cycle, and code and code_valid are unchanged.
- en falling: at the first edge with en=0, v0 is cleared. Also at that edge, v1 and the partial sum and cnt are cleared, so a partial average is discarded. The output slot is unaffected.

## Timing
- Reset (async, immediate): q_r, c_r, v0, v1, sum, cnt, code, code_valid, ovf and bubble_cnt are all 0.
- Latency with AVG_LOG2=0: Q sampled at edge k gives code visible after edge k+2 (S0 at k, S1 at k+1, slot at k+2).
- Throughput is one sample per clock. With AVG_LOG2=A, there is one result per 2^A samples when en is continuous.
- code is stable while code_valid=1 and code_ready=0. code_valid never drops without a transfer or reset.
- code_ready is ignored when code_valid=0. It does not combinationally affect any output.
- ovf is registered and asserted in the cycle after the edge at which the drop decision is made.
- Reset deassertion: the first capture occurs at the first rising edge with rst=0 and en=1.

## Test plan
- AVG_LOG2=0, ready=1, Q=31'h0000FFFF held, en raised at edge 0 → code_valid=1 after edge 2 with code=16, then 16 every cycle. bubble_cnt=0.
- Boundary and bubble cases, AVG_LOG2=0:
  - Q=31'h7FFFFFFF → code 31.
  - Q=0 → code 0.
  - Q=31'h000003DF (10-deep, bit 5 clear) → code 10, and bubble_cnt increments per sample.
  - Q=31'h00000400 (isolated high bit) → code 0.
- AVG_LOG2=2, consecutive thermometer codes 10, 11, 12, 13 → one result, code=11 (46>>2). code_valid is low during the other three sample cycles.
- Backpressure, AVG_LOG2=0, Q=7 ones, code_ready=0 for 5 cycles:
  - The first result (7) is held.
  - ovf pulses on each following completed result.
  - Raising code_ready → a transfer completes, and a new result loads on the same edge with no gap.
- AVG_LOG2=2, en=0 for one cycle after 2 samples → the partial sum is discarded. The next output equals the average of the following 4 full samples only.
- rst pulsed asynchronously mid-cycle while code_valid=1 and bubble_cnt=5 → code_valid, code, ovf and bubble_cnt read 0 before the next edge. The first post-reset result appears 2 edges after the first enabled capture.

Source files
------------

// File: rtl/flash_thermo_encoder.sv
// Flash ADC back end: bubble-corrects a comparator thermometer word, converts it to binary,
// optionally averages 2^AVG_LOG2 samples and hands results out over valid/ready.
module flash_thermo_encoder #(
    parameter int unsigned N_CMP     = 31,
    parameter int unsigned CODE_BITS = 5,
    parameter int unsigned AVG_LOG2  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_CMP-1:0]     Q,
    output logic [CODE_BITS-1:0] code,
    output logic                 code_valid,
    input  logic                 code_ready,
    output logic                 ovf,
    output logic [7:0]           bubble_cnt
);

    localparam int unsigned SUM_W = CODE_BITS + AVG_LOG2;
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [N_CMP-1:0]     q_r;
    logic                 v0;
    logic [N_CMP+1:0]     q_ext;
    logic [N_CMP-1:0]     t_c;
    logic [CODE_BITS-1:0] ones;
    logic                 bub;
    logic [CODE_BITS-1:0] c_r;
    logic                 bub_r;
    logic                 v1;
    logic [SUM_W-1:0]     sum;
    logic [SUM_W-1:0]     sum_next;
    logic [CNT_W-1:0]     cnt;
    logic                 done;
    logic [CODE_BITS-1:0] result;
    logic                 slot_free;

    // S0: comparator capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
            v0  <= 1'b0;
        end else begin
            v0 <= en;
            if (en) begin
                q_r <= Q;
            end
        end
    end

    // Below the lowest comparator reads as 1, above the highest as 0
    assign q_ext = {1'b0, q_r, 1'b1};

    // S1: three-input majority vote removes isolated bubbles
    always_comb begin
        t_c = '0;
        for (int i = 0; i < int'(N_CMP); i++) begin
            t_c[i] = (q_ext[i] & q_ext[i+1]) | (q_ext[i] & q_ext[i+2]) | (q_ext[i+1] & q_ext[i+2]);
        end
    end

    always_comb begin
        ones = '0;
        for (int i = 0; i < int'(N_CMP); i++) begin
            ones = ones + CODE_BITS'(t_c[i]);
        end
    end

    assign bub = (t_c != q_r);

    // S1 register; a low en flushes the sample in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_r   <= '0;
            bub_r <= 1'b0;
            v1    <= 1'b0;
        end else begin
            c_r   <= ones;
            bub_r <= bub;
            v1    <= v0 & en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (v1 && bub_r && (bubble_cnt != 8'hFF)) begin
            bubble_cnt <= bubble_cnt + 8'd1;
        end
    end

    // S2: accumulate 2^AVG_LOG2 samples; the last sample completes a result
    assign sum_next = sum + SUM_W'(c_r);
    assign done     = v1 & en & (cnt == CNT_LAST);
    assign result   = CODE_BITS'(sum_next >> AVG_LOG2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            cnt <= '0;
        end else if (!en) begin
            sum <= '0;
            cnt <= '0;
        end else if (v1) begin
            if (cnt == CNT_LAST) begin
                sum <= '0;
                cnt <= '0;
            end else begin
                sum <= sum_next;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Output slot: a transfer on this edge frees it for the new result
    assign slot_free = ~code_valid | code_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code       <= '0;
            code_valid <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (code_valid && code_ready) begin
                code_valid <= 1'b0;
            end
            if (done) begin
                if (slot_free) begin
                    code       <= result;
                    code_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_flash_thermo_encoder.sv
// Bench for flash_thermo_encoder: pass-through and 4-sample averaging instances share stimulus
// and are checked every cycle against a sample-level reference model.
module tb_flash_thermo_encoder;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        en   = 1'b0;
    logic [30:0] q    = '0;
    logic        rdy0 = 1'b1;
    logic        rdy2 = 1'b1;
    logic [4:0]  code0, code2;
    logic        valid0, valid2, ovf0, ovf2;
    logic [7:0]  bc0, bc2;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    flash_thermo_encoder #(.N_CMP(31), .CODE_BITS(5), .AVG_LOG2(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .Q(q),
        .code(code0), .code_valid(valid0), .code_ready(rdy0),
        .ovf(ovf0), .bubble_cnt(bc0)
    );

    flash_thermo_encoder #(.N_CMP(31), .CODE_BITS(5), .AVG_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .Q(q),
        .code(code2), .code_valid(valid2), .code_ready(rdy2),
        .ovf(ovf2), .bubble_cnt(bc2)
    );

    // Reference model state: sample pipeline, accumulation lists and output slots
    bit          p0_v;
    logic [30:0] p0_q;
    bit          p1_v;
    int          p1_c;
    bit          p1_b;
    int          asum[2];
    int          an[2];
    int          alen[2] = '{1, 4};
    bit          ev[2];
    int          ecode[2];
    bit          eovf[2];
    int          ebc;

    function automatic logic [30:0] th(input int n);
        logic [31:0] t;
        t = (32'd1 << n) - 32'd1;
        return t[30:0];
    endfunction

    // Count of comparators that a 2-of-3 neighbourhood vote says are on
    function automatic int corr_count(input logic [30:0] w, output bit bub);
        int  c;
        int  n;
        bit  lo, mid, hi;
        c   = 0;
        bub = 1'b0;
        for (int i = 0; i < 31; i++) begin
            lo  = (i == 0)  ? 1'b1 : w[i-1];
            mid = w[i];
            hi  = (i == 30) ? 1'b0 : w[i+1];
            n   = int'(lo) + int'(mid) + int'(hi);
            if (n >= 2) c++;
            if ((n >= 2) != mid) bub = 1'b1;
        end
        return c;
    endfunction

    task automatic model_reset();
        p0_v = 1'b0; p0_q = '0; p1_v = 1'b0; p1_c = 0; p1_b = 1'b0;
        for (int k = 0; k < 2; k++) begin
            asum[k] = 0; an[k] = 0; ev[k] = 1'b0; ecode[k] = 0; eovf[k] = 1'b0;
        end
        ebc = 0;
    endtask

    task automatic model_edge();
        bit rdy, got, b;
        int res;
        for (int k = 0; k < 2; k++) begin
            got = 1'b0;
            res = 0;
            if (!en) begin
                asum[k] = 0; an[k] = 0;
            end else if (p1_v) begin
                asum[k] += p1_c;
                an[k]++;
                if (an[k] == alen[k]) begin
                    res = asum[k] / alen[k];
                    got = 1'b1;
                    asum[k] = 0; an[k] = 0;
                end
            end
            rdy     = (k == 0) ? rdy0 : rdy2;
            eovf[k] = 1'b0;
            if (ev[k] && rdy) ev[k] = 1'b0;
            if (got) begin
                if (!ev[k]) begin
                    ev[k] = 1'b1; ecode[k] = res;
                end else begin
                    eovf[k] = 1'b1;
                end
            end
        end
        if (p1_v && p1_b && ebc < 255) ebc++;
        p1_v = p0_v && en;
        p1_c = corr_count(p0_q, b);
        p1_b = b;
        p0_v = en;
        if (en) p0_q = q;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic lit(input string name, input int dut_v, input int mdl_v, input int want);
        check({name, "_dut"}, dut_v, want);
        check({name, "_model"}, mdl_v, want);
    endtask

    task automatic compare_all();
        check("valid0", int'(valid0), int'(ev[0]));
        check("ovf0",   int'(ovf0),   int'(eovf[0]));
        check("bcnt0",  int'(bc0),    ebc);
        if (ev[0]) check("code0", int'(code0), ecode[0]);
        check("valid2", int'(valid2), int'(ev[1]));
        check("ovf2",   int'(ovf2),   int'(eovf[1]));
        check("bcnt2",  int'(bc2),    ebc);
        if (ev[1]) check("code2", int'(code2), ecode[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Flush, feed four codes, then expect exactly one averaged result
    task automatic avg_group(input int a, input int b, input int c, input int d, input int want);
        en = 1'b0; step();
        en = 1'b1; rdy2 = 1'b1;
        q = th(a); step();
        q = th(b); step();
        q = th(c); step();
        q = th(d); step();
        step();
        lit("avg_gap_valid", int'(valid2), int'(ev[1]), 0);
        step();
        lit("avg_valid", int'(valid2), int'(ev[1]), 1);
        lit("avg_code",  int'(code2),  ecode[1], want);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [30:0] tmp;
        int          pos;
        bit          hit;

        model_reset();
        run(2);
        lit("rst_valid", int'(valid0), int'(ev[0]), 0);
        lit("rst_bcnt",  int'(bc0),    ebc, 0);
        rst = 1'b0;

        // Pass-through latency and steady stream
        en = 1'b1; q = th(16); rdy0 = 1'b1; rdy2 = 1'b1;
        run(2);
        lit("lat_not_yet", int'(valid0), int'(ev[0]), 0);
        run(1);
        lit("lat_valid", int'(valid0), int'(ev[0]), 1);
        lit("code16",    int'(code0),  ecode[0], 16);
        run(4);
        lit("code16_hold", int'(code0), ecode[0], 16);
        lit("bcnt_clean",  int'(bc0),   ebc, 0);

        // Boundary words and bubbles
        q = th(31); run(3);
        lit("code31", int'(code0), ecode[0], 31);
        q = '0; run(3);
        lit("code0", int'(code0), ecode[0], 0);
        q = 31'h000003DF; run(3);
        lit("code_bubble", int'(code0), ecode[0], 10);
        lit("bcnt_one",    int'(bc0),   ebc, 1);
        run(1);
        lit("bcnt_two", int'(bc0), ebc, 2);
        q = 31'h00000400; run(3);
        lit("code_isolated", int'(code0), ecode[0], 0);
        lit("bcnt_five",     int'(bc0),   ebc, 5);

        // Averaging: 10+11+12+13 = 46, >>2 = 11
        avg_group(10, 11, 12, 13, 11);

        // Backpressure on the pass-through instance
        q = th(7); rdy0 = 1'b1; run(3);
        rdy0 = 1'b0; q = th(20);
        repeat (5) begin
            step();
            lit("bp_valid", int'(valid0), int'(ev[0]), 1);
            lit("bp_code",  int'(code0),  ecode[0], 7);
            lit("bp_ovf",   int'(ovf0),   int'(eovf[0]), 1);
        end
        rdy0 = 1'b1; step();
        lit("bp_rel_valid", int'(valid0), int'(ev[0]), 1);
        lit("bp_rel_code",  int'(code0),  ecode[0], 20);
        lit("bp_rel_ovf",   int'(ovf0),   int'(eovf[0]), 0);

        // Partial average discarded by en low: 4+5+6+7 = 22, >>2 = 5
        q = th(30); run(3);
        avg_group(4, 5, 6, 7, 5);

        // Async reset mid-cycle with a held result and bubble_cnt at 5
        rst = 1'b1; run(1); rst = 1'b0;
        q = 31'h000003DF; en = 1'b1; rdy0 = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (ebc == 5) hit = 1'b1;
        end
        check("bcnt_reach_5", ebc, 5);
        lit("pre_rst_valid", int'(valid0), int'(ev[0]), 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        lit("arst_valid", int'(valid0), int'(ev[0]), 0);
        lit("arst_code",  int'(code0),  ecode[0], 0);
        lit("arst_ovf",   int'(ovf0),   int'(eovf[0]), 0);
        lit("arst_bcnt",  int'(bc0),    ebc, 0);
        #1 rst = 1'b0;
        q = th(9);
        run(2);
        lit("post_rst_gap", int'(valid0), int'(ev[0]), 0);
        run(1);
        lit("post_rst_valid", int'(valid0), int'(ev[0]), 1);
        lit("post_rst_code",  int'(code0),  ecode[0], 9);

        // Randomized traffic
        repeat (2000) begin
            en = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 3))
                0, 1: q = th(int'($urandom_range(0, 31)));
                2: begin
                    tmp = th(int'($urandom_range(0, 31)));
                    pos = int'($urandom_range(0, 30));
                    tmp[pos] = ~tmp[pos];
                    q = tmp;
                end
                default: q = 31'($urandom);
            endcase
            rdy0 = ($urandom_range(0, 9) < 7);
            rdy2 = ($urandom_range(0, 9) < 7);
            step();
        end
        lit("bcnt_saturated", int'(bc0), ebc, 255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
